display_scan_ctrl: RTL and testbench

//  Upstream stage of mux_display. Generates the 64 Hz select (clk_aux) that alternates the T and V
//  7-seg digits, drives the two digit enables with a blanking gap at each switch (anti-ghosting),
//  and double-buffers both segment codes so updates land only at a frame boundary (no tearing).

---
 rtl/display_scan_ctrl_pkg.sv | 26 ++
 rtl/display_scan_ctrl_if.sv | 23 ++
 rtl/display_scan_ctrl_prescaler.sv | 38 +++
 rtl/display_scan_ctrl.sv | 100 ++++++++++
 tb/tb_display_scan_ctrl.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/display_scan_ctrl_pkg.sv
// Shared definitions for the display scan controller: FSM state encoding,
// digit-enable level helper and a constant-function log2 used for counter sizing.
package display_scan_ctrl_pkg;

   typedef enum logic [1:0] {
      BLANK_T = 2'b00,
      SHOW_T  = 2'b01,
      BLANK_V = 2'b10,
      SHOW_V  = 2'b11
   } scanState_e;

   localparam logic [6:0] SEG_BLANK = 7'h00;

   // Minimum of one bit so a degenerate HALF of 1 still yields a legal counter.
   function automatic int ceilLog2(input int value);
      int width;
      width = 1;
      while ((1 << width) < value) width++;
      return width;
   endfunction

   function automatic logic digOnLevel(input bit actLow);
      return actLow ? 1'b0 : 1'b1;
   endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Code-load and display-drive signals between a code producer and the scan controller.
interface display_scan_ctrl_if;

   logic [6:0] t_code;
   logic [6:0] v_code;
   logic       load;
   logic [6:0] Tseg_x;
   logic [6:0] Vseg_x;
   logic       clk_aux;
   logic [1:0] dig_en;
   logic       frame_tick;

   modport master (
      output t_code, v_code, load,
      input  Tseg_x, Vseg_x, clk_aux, dig_en, frame_tick
   );

   modport slave (
      input  t_code, v_code, load,
      output Tseg_x, Vseg_x, clk_aux, dig_en, frame_tick
   );

endinterface

// File: rtl/display_scan_ctrl_prescaler.sv
// Phase counter for the digit scan: counts 0..HALF-1 and flags the last blank
// cycle and the last cycle of each digit phase.
module scan_prescaler
   import display_scan_ctrl_pkg::*;
#(
   parameter int CLK_HZ    = 50_000_000,
   parameter int SCAN_HZ   = 64,
   parameter int BLANK_CYC = 1000
) (
   input  logic clk,
   input  logic rst_n,
   output logic end_blank_o,
   output logic end_phase_o
);

   localparam int HALF = CLK_HZ / (2 * SCAN_HZ);
   localparam int CW   = ceilLog2(HALF);

   localparam logic [CW-1:0] PHASE_LAST = CW'(HALF - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign end_phase_o = (cnt_q == PHASE_LAST);
   assign end_blank_o = (cnt_q == BLANK_LAST);

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (end_phase_o) cnt_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/display_scan_ctrl.sv
// Two-digit scan controller: alternates T/V digits with a blanking gap at each
// switch and double-buffers the segment codes so they change only between frames.
module display_scan_ctrl
   import display_scan_ctrl_pkg::*;
#(
   parameter int CLK_HZ      = 50_000_000,
   parameter int SCAN_HZ     = 64,
   parameter int BLANK_CYC   = 1000,
   parameter int DIG_ACT_LOW = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   display_scan_ctrl_if.slave   scan
);

   localparam logic       DIG_ON   = digOnLevel(DIG_ACT_LOW != 0);
   localparam logic       DIG_OFF  = ~DIG_ON;
   localparam logic [1:0] DIG_NONE = {DIG_OFF, DIG_OFF};
   localparam logic [1:0] DIG_T    = {DIG_ON,  DIG_OFF};
   localparam logic [1:0] DIG_V    = {DIG_OFF, DIG_ON};

   scanState_e state_q;
   logic       clkAux_q;
   logic [1:0] digEn_q;
   logic [6:0] tSeg_q;
   logic [6:0] vSeg_q;
   logic [6:0] tShadow_q;
   logic [6:0] vShadow_q;
   logic       pending_q;

   logic endBlank;
   logic endPhase;
   logic frameBoundary;

   scan_prescaler #(
      .CLK_HZ    (CLK_HZ),
      .SCAN_HZ   (SCAN_HZ),
      .BLANK_CYC (BLANK_CYC)
   ) u_prescaler (
      .clk         (clk),
      .rst_n       (rst_n),
      .end_blank_o (endBlank),
      .end_phase_o (endPhase)
   );

   assign frameBoundary = (state_q == SHOW_V) && endPhase;

   // Outputs are loaded with the value for the state being entered, so they
   // switch on the same edge as the state register. A load on the boundary
   // cycle refills the shadows while the previous shadows are applied.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= BLANK_T;
         clkAux_q  <= 1'b1;
         digEn_q   <= DIG_NONE;
         tSeg_q    <= SEG_BLANK;
         vSeg_q    <= SEG_BLANK;
         tShadow_q <= SEG_BLANK;
         vShadow_q <= SEG_BLANK;
         pending_q <= 1'b0;
      end else begin
         case (state_q)
            BLANK_T: if (endBlank) begin
               state_q <= SHOW_T;
               digEn_q <= DIG_T;
            end
            SHOW_T: if (endPhase) begin
               state_q  <= BLANK_V;
               clkAux_q <= 1'b0;
               digEn_q  <= DIG_NONE;
            end
            BLANK_V: if (endBlank) begin
               state_q <= SHOW_V;
               digEn_q <= DIG_V;
            end
            SHOW_V: if (endPhase) begin
               state_q  <= BLANK_T;
               clkAux_q <= 1'b1;
               digEn_q  <= DIG_NONE;
               if (pending_q) begin
                  tSeg_q <= tShadow_q;
                  vSeg_q <= vShadow_q;
               end
            end
         endcase
         if (scan.load) begin
            tShadow_q <= scan.t_code;
            vShadow_q <= scan.v_code;
         end
         pending_q <= scan.load | (pending_q & ~frameBoundary);
      end
   end

   assign scan.Tseg_x     = tSeg_q;
   assign scan.Vseg_x     = vSeg_q;
   assign scan.clk_aux    = clkAux_q;
   assign scan.dig_en     = digEn_q;
   assign scan.frame_tick = frameBoundary;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl with HALF=10, BLANK_CYC=2, active-low digit enables.
module tb_display_scan_ctrl;

   logic clk;
   logic rst_n;
   int   numCompared;
   int   numMismatched;

   display_scan_ctrl_if scanIf ();

   display_scan_ctrl #(
      .CLK_HZ      (1280),
      .SCAN_HZ     (64),
      .BLANK_CYC   (2),
      .DIG_ACT_LOW (1)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .scan  (scanIf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: cycle index since reset release plus the load buffering rules.
   int         mCycle;
   logic [6:0] mShT, mShV, mSegT, mSegV;
   bit         mPend;

   typedef struct {
      logic       expClkAux;
      logic [1:0] expDigEn;
      logic       expTick;
   } scanVec_t;

   scanVec_t scanTable[20];

   task automatic checkOutput(input string name, input int actual, input int expected);
      numCompared++;
      if (actual != expected) begin
         numMismatched++;
         $display("[TB] FAIL %s cycle %0d: got %0h, expected %0h", name, mCycle, actual, expected);
      end
   endtask

   task automatic modelReset();
      mCycle = 0;
      mShT = 7'h00; mShV = 7'h00; mSegT = 7'h00; mSegV = 7'h00;
      mPend = 0;
   endtask

   task automatic modelStep(input logic ld, input logic [6:0] t, input logic [6:0] v);
      bit boundary;
      boundary = (mCycle % 20) == 19;
      if (boundary && mPend) begin
         mSegT = mShT;
         mSegV = mShV;
      end
      if (boundary) mPend = 0;
      if (ld) begin
         mShT = t;
         mShV = v;
         mPend = 1;
      end
      mCycle++;
   endtask

   // Called just after a falling edge: compare against the model, drive this
   // cycle's inputs, then advance to the next falling edge.
   task automatic applyStimulus(input logic ld, input logic [6:0] t, input logic [6:0] v);
      logic       expClk;
      logic [1:0] expDig;
      int         pos;
      expClk = ((mCycle / 10) % 2) == 0;
      pos    = mCycle % 10;
      if (pos < 2)     expDig = 2'b11;
      else if (expClk) expDig = 2'b01;
      else             expDig = 2'b10;
      checkOutput("model_clk_aux", int'(scanIf.clk_aux), int'(expClk));
      checkOutput("model_dig_en", int'(scanIf.dig_en), int'(expDig));
      checkOutput("model_frame_tick", int'(scanIf.frame_tick), int'((mCycle % 20) == 19));
      checkOutput("model_Tseg", int'(scanIf.Tseg_x), int'(mSegT));
      checkOutput("model_Vseg", int'(scanIf.Vseg_x), int'(mSegV));
      scanIf.load   = ld;
      scanIf.t_code = t;
      scanIf.v_code = v;
      @(posedge clk);
      modelStep(ld, t, v);
      @(negedge clk);
   endtask

   task automatic resetDut();
      rst_n = 1'b0;
      scanIf.load = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      modelReset();
   endtask

   task automatic checkSegs(input string name, input logic [6:0] t, input logic [6:0] v);
      checkOutput({name, "_T"}, int'(scanIf.Tseg_x), int'(t));
      checkOutput({name, "_V"}, int'(scanIf.Vseg_x), int'(v));
   endtask

   initial begin
      numCompared   = 0;
      numMismatched = 0;
      modelReset();
      scanIf.load   = 1'b0;
      scanIf.t_code = 7'h00;
      scanIf.v_code = 7'h00;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      checkOutput("reset_clk_aux", int'(scanIf.clk_aux), 1);
      checkOutput("reset_dig_en", int'(scanIf.dig_en), 3);
      checkOutput("reset_tick", int'(scanIf.frame_tick), 0);
      checkSegs("reset_seg", 7'h00, 7'h00);

      for (int i = 0; i < 20; i++) begin
         scanTable[i].expClkAux = (i < 10);
         if (i < 2)       scanTable[i].expDigEn = 2'b11;
         else if (i < 10) scanTable[i].expDigEn = 2'b01;
         else if (i < 12) scanTable[i].expDigEn = 2'b11;
         else             scanTable[i].expDigEn = 2'b10;
         scanTable[i].expTick = (i == 19);
      end

      // Scan timing with no loads, from the table.
      resetDut();
      for (int i = 0; i < 20; i++) begin
         checkOutput("tbl_clk_aux", int'(scanIf.clk_aux), int'(scanTable[i].expClkAux));
         checkOutput("tbl_dig_en", int'(scanIf.dig_en), int'(scanTable[i].expDigEn));
         checkOutput("tbl_tick", int'(scanIf.frame_tick), int'(scanTable[i].expTick));
         applyStimulus(1'b0, 7'h00, 7'h00);
      end
      checkOutput("tbl_wrap_clk_aux", int'(scanIf.clk_aux), 1);

      // Single load mid-frame lands after the boundary.
      resetDut();
      for (int k = 0; k < 22; k++) begin
         if (k == 19) checkSegs("s2_before", 7'h00, 7'h00);
         if (k == 20) checkSegs("s2_after", 7'h06, 7'h5B);
         applyStimulus(k == 5, 7'h06, 7'h5B);
      end

      // Two loads in one frame: last one wins.
      resetDut();
      for (int k = 0; k < 22; k++) begin
         if (k == 20) checkSegs("s3_last_wins", 7'h4F, 7'h66);
         if (k == 3)      applyStimulus(1'b1, 7'h06, 7'h06);
         else if (k == 8) applyStimulus(1'b1, 7'h4F, 7'h66);
         else             applyStimulus(1'b0, 7'h00, 7'h00);
      end

      // Load on the boundary cycle is deferred one frame.
      resetDut();
      for (int k = 0; k < 42; k++) begin
         if (k == 20) checkSegs("s4_not_yet", 7'h00, 7'h00);
         if (k == 39) checkSegs("s4_still_old", 7'h00, 7'h00);
         if (k == 40) checkSegs("s4_applied", 7'h3F, 7'h3F);
         applyStimulus(k == 19, 7'h3F, 7'h3F);
      end

      // Reset in SHOW_V with a load pending.
      resetDut();
      for (int k = 0; k < 14; k++) applyStimulus(k == 8, 7'h12, 7'h34);
      checkOutput("s5_pre_dig_en", int'(scanIf.dig_en), 2);
      rst_n = 1'b0;
      #1;
      checkOutput("s5_rst_dig_en", int'(scanIf.dig_en), 3);
      checkOutput("s5_rst_clk_aux", int'(scanIf.clk_aux), 1);
      checkSegs("s5_rst_seg", 7'h00, 7'h00);
      @(negedge clk);
      rst_n = 1'b1;
      modelReset();
      for (int k = 0; k < 42; k++) begin
         if (k == 20 || k == 40) checkSegs("s5_pending_dropped", 7'h00, 7'h00);
         applyStimulus(1'b0, 7'h00, 7'h00);
      end

      // Random loads against the model, plus overlap and period checks.
      resetDut();
      begin
         int   lastRise;
         logic prevClk;
         lastRise = -1;
         prevClk  = 1'b1;
         for (int k = 0; k < 1000; k++) begin
            checkOutput("rand_dig_overlap", int'(scanIf.dig_en == 2'b00), 0);
            if (scanIf.clk_aux && !prevClk) begin
               if (lastRise >= 0) checkOutput("rand_clk_aux_period", k - lastRise, 20);
               lastRise = k;
            end
            prevClk = scanIf.clk_aux;
            applyStimulus($urandom_range(0, 3) == 0, 7'($urandom), 7'($urandom));
         end
         checkOutput("rand_saw_rises", int'(lastRise >= 960), 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
      $finish;
   end

endmodule
